// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between two word sources, the arbiter and its consumer.
// The slave modport is the arbiter side; master is the sources/consumer side.
interface mux_rr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                    a_valid;
    logic [2*DATA_WIDTH-1:0] a_data;
    logic                    a_ready;
    logic                    b_valid;
    logic [2*DATA_WIDTH-1:0] b_data;
    logic                    b_ready;
    logic                    out_valid;
    logic [2*DATA_WIDTH-1:0] out_data;
    logic                    out_ready;
    logic                    sel;
    logic [CNT_WIDTH-1:0]    a_count;
    logic [CNT_WIDTH-1:0]    b_count;

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, sel, a_count, b_count
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, sel, a_count, b_count
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Two-source round-robin arbiter feeding a one-entry output register plus mux select.
// Latency: one cycle from accept to out_valid; no combinational data path to the output.
// Backpressure: both readies drop while a word is held and out_ready is low.
module mux_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_rr_arbiter_if.slave   io_bus
);
    logic                    w_can_accept;
    logic                    w_grant_a;
    logic                    w_grant_b;
    logic                    w_xfer_a;
    logic                    w_xfer_b;

    logic                    r_out_valid;
    logic [2*DATA_WIDTH-1:0] r_out_data;
    logic                    r_sel;
    logic                    r_last_grant;
    logic [CNT_WIDTH-1:0]    r_a_count;
    logic [CNT_WIDTH-1:0]    r_b_count;

    // The output slot is free when empty or being drained this cycle.
    assign w_can_accept = !r_out_valid || io_bus.out_ready;

    // On contention the source that did not win the last transfer goes next.
    assign w_grant_a = io_bus.a_valid && (!io_bus.b_valid || r_last_grant);
    assign w_grant_b = io_bus.b_valid && (!io_bus.a_valid || !r_last_grant);

    // rst_n gating keeps both readies low for the whole reset interval.
    assign w_xfer_a = rst_n && w_can_accept && w_grant_a;
    assign w_xfer_b = rst_n && w_can_accept && w_grant_b;

    assign io_bus.a_ready   = w_xfer_a;
    assign io_bus.b_ready   = w_xfer_b;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.sel       = r_sel;
    assign io_bus.a_count   = r_a_count;
    assign io_bus.b_count   = r_b_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_xfer_a) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= io_bus.a_data;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b0;
        end else if (w_xfer_b) begin
            r_out_valid  <= 1'b1;
            r_out_data   <= io_bus.b_data;
            r_sel        <= 1'b1;
            r_last_grant <= 1'b1;
        end else if (io_bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Counters stick at all-ones; the transfer itself still goes through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_count <= '0;
            r_b_count <= '0;
        end else begin
            if (w_xfer_a && (r_a_count != {CNT_WIDTH{1'b1}}))
                r_a_count <= r_a_count + CNT_WIDTH'(1);
            if (w_xfer_b && (r_b_count != {CNT_WIDTH{1'b1}}))
                r_b_count <= r_b_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Two-source round-robin arbiter with a one-entry registered output stage.
- Sits directly upstream of the 2:1 word multiplexer. It decides which of two 2*DATA_WIDTH-bit sources is forwarded, registers the chosen word, and presents the registered source select (`sel`, the mux select line: 0 = a, 1 = b).
- Adds valid/ready flow control and per-source accepted-word counters.

Parameters:
DATA_WIDTH  8   half bus width; all data buses are 2*DATA_WIDTH bits
CNT_WIDTH   16  width of the per-source accepted-word counters

Ports:
clk        input   1             rising-edge clock
rst_n      input   1             asynchronous active-low reset
a_valid    input   1             source a offers a word
a_data     input   2*DATA_WIDTH  source a word
a_ready    output  1             source a word accepted this cycle
b_valid    input   1             source b offers a word
b_data     input   2*DATA_WIDTH  source b word
b_ready    output  1             source b word accepted this cycle
out_valid  output  1             out_data holds a word
out_data   output  2*DATA_WIDTH  registered selected word
out_ready  input   1             consumer takes the word this cycle
sel        output  1             source of out_data (0 = a, 1 = b); drives the downstream mux select
a_count    output  CNT_WIDTH     words accepted from a, saturating
b_count    output  CNT_WIDTH     words accepted from b, saturating

Behaviour:
- Interface (decided): one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - out_valid = 0, out_data = 0, sel = 0.
  - a_count = 0, b_count = 0.
  - Internal last_grant = 1, so source a wins the first contention.
- Reset asserted mid-operation: all registers clear immediately, without waiting for a clock edge. Any held word is discarded. a_ready and b_ready are 0 while rst_n = 0.
- can_accept = !out_valid || out_ready. This is combinational.
- Grant is combinational from a_valid, b_valid and last_grant:
  - Only a_valid = 1: grant a.
  - Only b_valid = 1: grant b.
  - Both valid: grant the source that is not last_grant.
  - Neither valid: no grant.
- a_ready = can_accept && grant_a. b_ready = can_accept && grant_b. At most one ready is high in any cycle.
- Ready may depend on valid. Valid must not depend on ready (source rule).
- Transfer on source x occurs when x_valid && x_ready. On that clock edge:
  - out_data <= x_data, out_valid <= 1, sel <= x.
  - last_grant <= x.
  - x_count increments by 1.
- last_grant updates only on a transfer, not on an offer alone.
- Latency: a word accepted at edge N appears on out_data, with out_valid = 1, after edge N. That is one cycle, with no combinational input-to-output data path.
- Drain: out_valid && out_ready with no new transfer → out_valid <= 0 at the edge. out_data and sel keep their last values.
- Simultaneous drain and accept: the new word replaces the old one in the same edge and out_valid stays 1. This gives full throughput of 1 word per cycle.
- Stall: while out_valid && !out_ready, out_data, sel and out_valid hold stable and both readies are 0.
- Counters:
  - Saturate at 2^CNT_WIDTH-1. No wrap to 0.
  - Transfers after saturation still complete; only the counter holds.
- Data width: data passes through unmodified. No truncation or extension.

Test Plan:
- Reset: hold rst_n = 0 with all inputs driven → out_valid = 0, sel = 0, counts = 0, a_ready = b_ready = 0. Release on a non-edge time and confirm the first edge is clean.
- Single source: a_valid = 1, a_data = 16'h1234, out_ready = 1 → a_ready = 1 the same cycle. Next cycle out_data = 16'h1234, sel = 0, a_count = 1.
- Contention fairness: both valid continuously, a_data = 16'hAAAA, b_data = 16'h5555, out_ready = 1 for 4 cycles → accepted order a, b, a, b. sel toggles 0, 1, 0, 1. a_count = b_count = 2.
- Backpressure: fill the output with 16'hBEEF from b, then out_ready = 0 for 5 cycles while a_valid = 1 → out_data stays 16'hBEEF, sel stays 1, a_ready = 0. On out_ready = 1, a's word is accepted in the same cycle the old word drains.
- Saturation: CNT_WIDTH = 2, 5 transfers from a → a_count = 3 after the 3rd transfer and stays 3. All 5 words still appear on out_data.
- Reset mid-stall: out_valid = 1 with held 16'hCAFE, pulse rst_n low between edges → out_valid drops to 0 asynchronously. After release, a grant goes to a first on contention.
